// File: rtl/act_mem_ext_loader_pkg.sv
// Shared activation-memory constants and the external loader state type.
package act_mem_ext_loader_pkg;

  localparam int unsigned BIT_WIDTH_EXTERNAL_PORT        = 32;
  localparam int unsigned INPUT_CHANNEL_DATA_WIDTH       = 8;
  localparam int unsigned N_DIM_ARRAY                    = 4;
  localparam int unsigned INPUT_CHANNEL_ADDR_SIZE        = 16;
  localparam int unsigned ACT_MEM_SRAM_numWordAddr       = 11;
  localparam int unsigned ACT_MEM_SRAM_blocks_per_column = 4;

  // Row address within one buffer half: word address plus block select.
  localparam int unsigned ACT_LD_ROW_ADDR_W =
    ACT_MEM_SRAM_numWordAddr + $clog2(ACT_MEM_SRAM_blocks_per_column);
  localparam int unsigned ACT_LD_LEN_W = INPUT_CHANNEL_ADDR_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUF,
    LOAD,
    DONE
  } act_ld_state_t;

endpackage

// File: rtl/act_mem_ext_loader.sv
// Streams activation tiles from the external write port into one half of the
// double-buffered activation memory (one byte per SRAM column per row).
// Owns ping-pong write-buffer selection, per-buffer full flags and the read
// buffer pointer that follows consumer releases.
//   clk_i/rst_ni              clock, synchronous active-low reset
//   start_i, base_row_i,
//   len_bytes_i               tile request (sampled on accepted start)
//   ext_valid_i/ext_data_i,
//   ext_ready_o               external beat handshake
//   mem_we_o/mem_row_o,
//   mem_buf_o/mem_wdata_o     registered SRAM write port
//   release_i/release_buf_i   consumer buffer release
//   buf_full_o, rd_buf_o      buffer status
//   busy_o, done_o            loader status
module act_mem_ext_loader
  import act_mem_ext_loader_pkg::*;
#(
  parameter int unsigned EXT_W      = BIT_WIDTH_EXTERNAL_PORT,
  parameter int unsigned DATA_W     = INPUT_CHANNEL_DATA_WIDTH,
  parameter int unsigned N_BANKS    = N_DIM_ARRAY,
  parameter int unsigned ROW_ADDR_W = ACT_LD_ROW_ADDR_W,
  parameter int unsigned LEN_W      = ACT_LD_LEN_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ROW_ADDR_W-1:0] base_row_i,
  input  logic [LEN_W-1:0]      len_bytes_i,
  input  logic                  ext_valid_i,
  input  logic [EXT_W-1:0]      ext_data_i,
  output logic                  ext_ready_o,
  output logic [N_BANKS-1:0]    mem_we_o,
  output logic [ROW_ADDR_W-1:0] mem_row_o,
  output logic                  mem_buf_o,
  output logic [EXT_W-1:0]      mem_wdata_o,
  input  logic                  release_i,
  input  logic                  release_buf_i,
  output logic [1:0]            buf_full_o,
  output logic                  rd_buf_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned BANK_SH = $clog2(N_BANKS);

  if (EXT_W != N_BANKS * DATA_W) begin : g_width_check
    $error("act_mem_ext_loader: EXT_W must equal N_BANKS*DATA_W");
  end

  act_ld_state_t         state_q, state_d;
  logic                  wr_buf_q, rd_buf_q;
  logic [1:0]            buf_full_q, buf_full_d;
  logic [ROW_ADDR_W-1:0] row_q;
  logic [LEN_W-1:0]      len_q, beats_left_q, beats_total;
  logic [LEN_W:0]        len_round;
  logic [BANK_SH-1:0]    rem;
  logic [N_BANKS-1:0]    tail_mask;
  logic                  accept, last_beat, rel_ok, done_set, wr_buf_free;

  assign accept    = ext_valid_i && (state_q == LOAD);
  assign last_beat = (beats_left_q == LEN_W'(1));
  assign rel_ok    = release_i && buf_full_q[release_buf_i];
  assign done_set  = (state_q == DONE) && (len_q != '0);
  // A release of the target buffer in the same cycle frees it immediately.
  assign wr_buf_free = !buf_full_q[wr_buf_q] || (release_i && (release_buf_i == wr_buf_q));

  // ceil(len / N_BANKS), computed one bit wider so the rounding cannot overflow.
  assign len_round   = {1'b0, len_bytes_i} + (LEN_W+1)'(N_BANKS - 1);
  assign beats_total = LEN_W'(len_round >> BANK_SH);
  assign rem         = len_q[BANK_SH-1:0];

  always_comb begin
    tail_mask = '0;
    for (int unsigned k = 0; k < N_BANKS; k++) begin
      tail_mask[k] = (rem == '0) || (k < 32'(rem));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ext_ready_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          if (len_bytes_i == '0)          state_d = DONE;
          else if (buf_full_q[wr_buf_q])  state_d = WAIT_BUF;
          else                            state_d = LOAD;
        end
      end
      WAIT_BUF: begin
        if (wr_buf_free) state_d = LOAD;
      end
      LOAD: begin
        ext_ready_o = 1'b1;
        if (accept && last_beat) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Release and completion may hit different buffers in one cycle; both apply.
  always_comb begin
    buf_full_d = buf_full_q;
    if (rel_ok)   buf_full_d[release_buf_i] = 1'b0;
    if (done_set) buf_full_d[wr_buf_q]      = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_buf_q     <= 1'b0;
      rd_buf_q     <= 1'b0;
      buf_full_q   <= '0;
      row_q        <= '0;
      len_q        <= '0;
      beats_left_q <= '0;
      mem_we_o     <= '0;
      mem_row_o    <= '0;
      mem_buf_o    <= 1'b0;
      mem_wdata_o  <= '0;
    end else begin
      mem_we_o   <= '0;
      buf_full_q <= buf_full_d;
      if (state_q == IDLE && start_i) begin
        row_q        <= base_row_i;
        len_q        <= len_bytes_i;
        beats_left_q <= beats_total;
      end
      if (accept) begin
        mem_we_o     <= last_beat ? tail_mask : '1;
        mem_row_o    <= row_q;
        mem_buf_o    <= wr_buf_q;
        mem_wdata_o  <= ext_data_i;
        row_q        <= row_q + ROW_ADDR_W'(1);
        beats_left_q <= beats_left_q - LEN_W'(1);
      end
      if (rel_ok)   rd_buf_q <= ~rd_buf_q;
      if (done_set) wr_buf_q <= ~wr_buf_q;
    end
  end

  assign buf_full_o = buf_full_q;
  assign rd_buf_o   = rd_buf_q;

endmodule

// File: tb/tb_act_mem_ext_loader.sv
module tb_act_mem_ext_loader;

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_LOAD = 2;
  localparam int P_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [12:0] base_row = '0;
  logic [15:0] len_bytes = '0;
  logic        ext_valid = 1'b0;
  logic [31:0] ext_data = '0;
  logic        ext_ready;
  logic [3:0]  mem_we;
  logic [12:0] mem_row;
  logic        mem_buf;
  logic [31:0] mem_wdata;
  logic        release_v = 1'b0;
  logic        release_buf = 1'b0;
  logic [1:0]  buf_full;
  logic        rd_buf;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  act_mem_ext_loader #(
    .EXT_W(32), .DATA_W(8), .N_BANKS(4), .ROW_ADDR_W(13), .LEN_W(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_row_i(base_row),
    .len_bytes_i(len_bytes), .ext_valid_i(ext_valid), .ext_data_i(ext_data),
    .ext_ready_o(ext_ready), .mem_we_o(mem_we), .mem_row_o(mem_row),
    .mem_buf_o(mem_buf), .mem_wdata_o(mem_wdata), .release_i(release_v),
    .release_buf_i(release_buf), .buf_full_o(buf_full), .rd_buf_o(rd_buf),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Tile-level reference: tracks what phase the loader is in, the list of rows
  // a tile occupies, and the buffer bookkeeping, all from plain arithmetic.
  int       ph = P_IDLE;
  bit       m_wr = 0, m_rd = 0, m_acc = 0;
  bit [1:0] m_full = 0;
  int       t_base, t_len, t_beats, t_idx;
  int       e_we = 0, e_row = 0, e_buf = 0;
  logic [31:0] e_data = '0;

  always @(posedge clk) begin
    bit [1:0] f_old;
    bit       wr_old, set_done;
    m_acc = 0;
    if (!rst_n) begin
      ph = P_IDLE; m_wr = 0; m_rd = 0; m_full = 0; e_we = 0;
    end else begin
      f_old = m_full; wr_old = m_wr; set_done = 0; e_we = 0;
      case (ph)
        P_IDLE: if (start) begin
          t_base = int'(base_row); t_len = int'(len_bytes);
          t_beats = (t_len + 3) / 4; t_idx = 0;
          if (t_len == 0)         ph = P_DONE;
          else if (f_old[wr_old]) ph = P_WAIT;
          else                    ph = P_LOAD;
        end
        P_WAIT: if (!f_old[wr_old] || (release_v && release_buf == wr_old)) ph = P_LOAD;
        P_LOAD: if (ext_valid) begin
          if (t_idx == t_beats - 1 && (t_len % 4) != 0) e_we = (1 << (t_len % 4)) - 1;
          else                                         e_we = 15;
          e_row  = (t_base + t_idx) % 8192;
          e_buf  = int'(wr_old);
          e_data = ext_data;
          t_idx++;
          m_acc = 1;
          if (t_idx == t_beats) ph = P_DONE;
        end
        default: begin
          set_done = (t_len != 0);
          ph = P_IDLE;
        end
      endcase
      if (release_v && f_old[release_buf]) begin m_full[release_buf] = 0; m_rd = ~m_rd; end
      if (set_done) begin m_full[wr_old] = 1; m_wr = ~m_wr; end
    end
  end

  // Write log for literal checks on address sequences.
  logic [12:0] lg_row [64];
  logic        lg_buf [64];
  logic [3:0]  lg_we  [64];
  int          log_n = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ext_ready", ext_ready, ph == P_LOAD);
      chk("busy", busy, ph != P_IDLE);
      chk("done", done, ph == P_DONE);
      chk("buf_full", buf_full, m_full);
      chk("rd_buf", rd_buf, m_rd);
      chk("mem_we", mem_we, e_we);
      if (e_we != 0) begin
        chk("mem_row", mem_row, e_row);
        chk("mem_buf", mem_buf, e_buf);
        chk("mem_wdata", mem_wdata, e_data);
      end
    end
    if (mem_we != 0 && log_n < 64) begin
      lg_row[log_n] = mem_row; lg_buf[log_n] = mem_buf; lg_we[log_n] = mem_we;
      log_n++;
    end
  end

  logic [31:0] bd [16];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); cmp_en = 1'b1; tick(); rst_n = 1'b1;
  endtask

  task automatic start_tile(input logic [12:0] b, input logic [15:0] l);
    start = 1'b1; base_row = b; len_bytes = l; tick(); start = 1'b0;
  endtask

  task automatic send_beats(input int n, input bit gap);
    int i = 0;
    int budget = 0;
    while (i < n && budget < 200) begin
      if (gap) begin ext_valid = 1'b0; tick(); budget++; end
      ext_valid = 1'b1; ext_data = bd[i]; tick(); budget++;
      if (m_acc) i++;
    end
    ext_valid = 1'b0;
    if (i < n) chk("send_timeout", i, n);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ph != P_IDLE && n < 50) begin tick(); n++; end
    if (ph != P_IDLE) chk("idle_timeout", ph, P_IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    do_reset();
    chk("rst_buf_full", buf_full, 2'b00);
    chk("rst_we", mem_we, 4'h0);
    chk("rst_busy", busy, 1'b0);

    // Full tile, no stalls.
    b = log_n;
    for (int k = 0; k < 4; k++) bd[k] = 32'h03020100 + 32'h04040404 * k;
    start_tile(13'h10, 16'd16);
    send_beats(4, 1'b0);
    chk("t1_done_last", done, 1'b1);
    chk("t1_we_last", mem_we, 4'hF);
    chk("t1_data_last", mem_wdata, 32'h0F0E0D0C);
    tick();
    chk("t1_done_drop", done, 1'b0);
    chk("t1_full", buf_full, 2'b01);
    for (int k = 0; k < 4; k++) begin
      chk("t1_row", lg_row[b+k], 13'h10 + k);
      chk("t1_buf", lg_buf[b+k], 1'b0);
      chk("t1_we", lg_we[b+k], 4'hF);
    end

    // Short tile with partial last row.
    do_reset();
    b = log_n;
    bd[0] = 32'h44332211; bd[1] = 32'h00776655;
    start_tile(13'h20, 16'd7);
    send_beats(2, 1'b0);
    wait_idle();
    chk("t2_we0", lg_we[b], 4'hF);
    chk("t2_we1", lg_we[b+1], 4'b0111);
    chk("t2_full", buf_full, 2'b01);

    // Row wrap, lands in buffer 1; trailing beats must not be consumed.
    b = log_n;
    bd[0] = 32'hA1A2A3A4; bd[1] = 32'hB1B2B3B4;
    start_tile(13'h1FFF, 16'd8);
    send_beats(2, 1'b0);
    ext_valid = 1'b1; ext_data = 32'hDEADBEEF;
    repeat (3) tick();
    ext_valid = 1'b0;
    chk("t3_row0", lg_row[b], 13'h1FFF);
    chk("t3_row1", lg_row[b+1], 13'h0000);
    chk("t3_buf", lg_buf[b], 1'b1);
    chk("t3_nlog", log_n - b, 2);
    chk("t3_full", buf_full, 2'b11);

    // Both halves full: third tile waits until buffer 0 is released.
    start_tile(13'h40, 16'd4);
    repeat (3) tick();
    chk("t4_wait_ready", ext_ready, 1'b0);
    chk("t4_wait_busy", busy, 1'b1);
    release_v = 1'b1; release_buf = 1'b0; tick(); release_v = 1'b0;
    chk("t4_load_ready", ext_ready, 1'b1);
    chk("t4_rd_buf", rd_buf, 1'b1);
    b = log_n;
    bd[0] = 32'h12345678;
    send_beats(1, 1'b0);
    wait_idle();
    chk("t4_buf", lg_buf[b], 1'b0);
    chk("t4_row", lg_row[b], 13'h40);

    // Free buffer 1, then load with valid toggling each cycle.
    release_v = 1'b1; release_buf = 1'b1; tick(); release_v = 1'b0;
    b = log_n;
    for (int k = 0; k < 3; k++) bd[k] = 32'hC0000000 + k;
    start_tile(13'h100, 16'd12);
    send_beats(3, 1'b1);
    wait_idle();
    for (int k = 0; k < 3; k++) chk("t5_row", lg_row[b+k], 13'h100 + k);
    chk("t5_nlog", log_n - b, 3);

    // Reset in the middle of a load, then a zero-length tile.
    release_v = 1'b1; release_buf = 1'b0; tick(); release_v = 1'b0;
    bd[0] = 32'h55555555;
    start_tile(13'h50, 16'd16);
    send_beats(1, 1'b0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t6_we", mem_we, 4'h0);
    chk("t6_full", buf_full, 2'b00);
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", ext_ready, 1'b0);
    chk("t6_rd", rd_buf, 1'b0);
    start_tile(13'h0, 16'd0);
    chk("t6_done", done, 1'b1);
    tick();
    chk("t6_done_drop", done, 1'b0);
    chk("t6_full_after", buf_full, 2'b00);
    // Release of an empty buffer is ignored.
    release_v = 1'b1; release_buf = 1'b1; tick(); release_v = 1'b0;
    chk("t6_rd_ignored", rd_buf, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
